// File: rtl/decode_issue_fifo_pkg.sv
// Shared defaults for the decode -> issue elastic buffer.
// Widths follow the global WF_ID_LENGTH / ISSUE_INSTR_INFO_LENGTH defines.
// Fallback values are supplied when the defines are absent.
// Optional feature macro used by the top: DECODE_FIFO_BYPASS_EN.
`ifndef WF_ID_LENGTH
`define WF_ID_LENGTH 6
`endif
`ifndef ISSUE_INSTR_INFO_LENGTH
`define ISSUE_INSTR_INFO_LENGTH 32
`endif

package decode_issue_fifo_pkg;
  localparam int DEF_DEPTH  = 4;
  localparam int DEF_WFID_W = `WF_ID_LENGTH;
  localparam int DEF_INFO_W = `ISSUE_INSTR_INFO_LENGTH;
endpackage

// File: rtl/decode_fifo_ptr.sv
// Wrap-bit pointer for the decode issue FIFO.
// The low PTR_W bits index the entry array.
// The extra MSB distinguishes full from empty when the indices match.
module decode_fifo_ptr #(
  parameter int PTR_W = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           inc,
  output logic [PTR_W:0] ptr
);

  // Advance by one slot when enabled; async active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr <= '0;
    else if (inc) ptr <= ptr + 1'b1;
  end

endmodule

// File: rtl/decode_issue_fifo.sv
// Elastic buffer between the wavefront decoder and the issue info table.
// Each entry carries a live bit, so a per-wavefront flush can kill records in place.
// A dead head is dropped silently on the cycle after it dies.
// Optional macro DECODE_FIFO_BYPASS_EN: when the FIFO is empty, a record the
// issue stage can take is driven straight to the outputs in the same cycle.
module decode_issue_fifo
  import decode_issue_fifo_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int WFID_W = DEF_WFID_W,
  parameter int INFO_W = DEF_INFO_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WFID_W-1:0]      in_wfid,
  input  logic [INFO_W-1:0]      in_info,
  input  logic                   out_ready,
  output logic                   f_decode_valid,
  output logic [WFID_W-1:0]      f_decode_wfid,
  output logic [INFO_W-1:0]      decode_wr_data,
  input  logic                   flush_valid,
  input  logic [WFID_W-1:0]      flush_wfid,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]    rd_ptr, wr_ptr;
  logic [PTR_W-1:0]  rd_idx, wr_idx;
  logic [WFID_W-1:0] mem_wfid [DEPTH];
  logic [INFO_W-1:0] mem_info [DEPTH];
  logic [DEPTH-1:0]  live;
  logic empty, full, push, store, pop, deliver, head_kill, in_kill, bypass;

  assign rd_idx     = rd_ptr[PTR_W-1:0];
  assign wr_idx     = wr_ptr[PTR_W-1:0];
  assign empty      = (rd_ptr == wr_ptr);
  assign full       = (rd_idx == wr_idx) && (rd_ptr[PTR_W] != wr_ptr[PTR_W]);
  assign fifo_count = wr_ptr - rd_ptr;

  // Ready depends only on registered occupancy, so a pop never frees a slot for a same-cycle push.
  assign in_ready  = !full;
  assign push      = in_valid && in_ready;
  assign in_kill   = flush_valid && (in_wfid == flush_wfid);
  assign head_kill = flush_valid && (mem_wfid[rd_idx] == flush_wfid);
  assign deliver   = !empty && live[rd_idx] && !head_kill && out_ready;
  assign pop       = !empty && (!live[rd_idx] || deliver);

`ifdef DECODE_FIFO_BYPASS_EN
  assign bypass = rst && empty && in_valid && out_ready && !in_kill;
`else
  assign bypass = 1'b0;
`endif
  assign store = push && !bypass;

  decode_fifo_ptr #(.PTR_W(PTR_W)) u_rd_ptr (.clk(clk), .rst(rst), .inc(pop),   .ptr(rd_ptr));
  decode_fifo_ptr #(.PTR_W(PTR_W)) u_wr_ptr (.clk(clk), .rst(rst), .inc(store), .ptr(wr_ptr));

  // Payload storage; only the live bits need a reset.
  always_ff @(posedge clk) begin
    if (store) begin
      mem_wfid[wr_idx] <= in_wfid;
      mem_info[wr_idx] <= in_info;
    end
  end

  // Live bits: flush kills every matching entry, and a matching incoming record is stored dead.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (flush_valid && (mem_wfid[i] == flush_wfid)) live[i] <= 1'b0;
      end
      if (store) live[wr_idx] <= !in_kill;
    end
  end

  // Output mux: bypass record, delivered head, or zeros when nothing is delivered.
  always_comb begin
    f_decode_valid = 1'b0;
    f_decode_wfid  = '0;
    decode_wr_data = '0;
    if (bypass) begin
      f_decode_valid = 1'b1;
      f_decode_wfid  = in_wfid;
      decode_wr_data = in_info;
    end else if (deliver) begin
      f_decode_valid = 1'b1;
      f_decode_wfid  = mem_wfid[rd_idx];
      decode_wr_data = mem_info[rd_idx];
    end
  end

endmodule
